debug_access_requester: RTL and testbench

DEBUG_ACCESS_REQUESTER -- requirements
Module: debug_access_requester

---
 rtl/debug_access_requester.sv | 155 +++++++++++++++
 tb/tb_debug_access_requester.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_access_requester.sv
// Key-gated debug-read requester: unlock with a key, then issue level-checked debug reads.
// Optional feature macro DBG_REQ_LOCKOUT_EN adds the failed-attempt counter and timed LOCKOUT state.
module debug_access_requester #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        unlock_valid,
    input  logic [31:0] unlock_key,
    input  logic [31:0] expected_key,
    input  logic        relock,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_level,
    output logic [3:0]  debug_level,
    input  logic [31:0] debug_output,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_error,
    output logic        unlocked,
    output logic        locked_out,
    output logic [2:0]  fsm_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // rsp_valid stays high with rsp_data/rsp_error frozen until rsp_ready is seen.
    localparam logic [2:0] S_LOCKED   = 3'd0;
    localparam logic [2:0] S_UNLOCKED = 3'd1;
    localparam logic [2:0] S_SETTLE   = 3'd2;
    localparam logic [2:0] S_RESP     = 3'd3;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] MIN_LEVEL   = 4'hA;

`ifdef DBG_REQ_LOCKOUT_EN
    localparam logic [2:0] S_LOCKOUT = 3'd4;
    localparam int         FW        = (MAX_FAILS < 2) ? 1 : $clog2(MAX_FAILS + 1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
    localparam logic [7:0]    LOCK_LAST = 8'(LOCKOUT_CYCLES - 1);

    logic [FW-1:0] fail_cnt;
    logic [7:0]    lock_timer;
`else
    // Lockout parameters have no effect in this build.
    localparam int unused_cfg = MAX_FAILS + LOCKOUT_CYCLES;
`endif

    logic [2:0]  state;
    logic [3:0]  settle_cnt;
    logic [3:0]  level_q;
    logic [31:0] data_q;
    logic        err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_LOCKED;
            settle_cnt <= '0;
            level_q    <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
`ifdef DBG_REQ_LOCKOUT_EN
            fail_cnt   <= '0;
            lock_timer <= '0;
`endif
        end else begin
            case (state)
                S_LOCKED: begin
                    if (unlock_valid) begin
                        if (unlock_key == expected_key) begin
                            state <= S_UNLOCKED;
`ifdef DBG_REQ_LOCKOUT_EN
                            fail_cnt <= '0;
`endif
                        end
`ifdef DBG_REQ_LOCKOUT_EN
                        else if (fail_cnt == FAIL_LAST) begin
                            state      <= S_LOCKOUT;
                            fail_cnt   <= '0;
                            lock_timer <= '0;
                        end else begin
                            fail_cnt <= fail_cnt + 1'b1;
                        end
`endif
                    end
                end
                S_UNLOCKED: begin
                    // relock wins over a request presented in the same cycle
                    if (relock) begin
                        state  <= S_LOCKED;
                        data_q <= '0;
                        err_q  <= 1'b0;
                    end else if (req_valid) begin
                        if (req_level >= MIN_LEVEL) begin
                            level_q    <= req_level;
                            settle_cnt <= '0;
                            state      <= S_SETTLE;
                        end else begin
                            data_q <= '0;
                            err_q  <= 1'b1;
                            state  <= S_RESP;
                        end
                    end
                end
                S_SETTLE: begin
                    if (relock) begin
                        state  <= S_LOCKED;
                        data_q <= '0;
                        err_q  <= 1'b0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        data_q <= debug_output;
                        err_q  <= 1'b0;
                        state  <= S_RESP;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    if (relock) begin
                        state  <= S_LOCKED;
                        data_q <= '0;
                        err_q  <= 1'b0;
                    end else if (rsp_ready) begin
                        state <= S_UNLOCKED;
                    end
                end
`ifdef DBG_REQ_LOCKOUT_EN
                S_LOCKOUT: begin
                    if (lock_timer == LOCK_LAST) begin
                        state <= S_LOCKED;
                    end else begin
                        lock_timer <= lock_timer + 8'd1;
                    end
                end
`endif
                default: state <= S_LOCKED;
            endcase
        end
    end

    // The target only sees a level while settling; every other state drives zero.
    assign debug_level = (state == S_SETTLE) ? level_q : 4'h0;
    assign req_ready   = (state == S_UNLOCKED);
    assign rsp_valid   = (state == S_RESP);
    assign rsp_data    = data_q;
    assign rsp_error   = err_q;
    assign unlocked    = (state == S_UNLOCKED) || (state == S_SETTLE) || (state == S_RESP);
    assign fsm_state   = state;
`ifdef DBG_REQ_LOCKOUT_EN
    assign locked_out  = (state == S_LOCKOUT);
`else
    assign locked_out  = 1'b0;
`endif

endmodule

// File: tb/tb_debug_access_requester.sv
// Directed-plus-random bench for debug_access_requester with a rule-level response model.
module tb_debug_access_requester;
    localparam int SETTLE  = 2;
    localparam int LOCKOUT = 64;
    localparam logic [31:0] KEY = 32'hCAFE_F00D;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        unlock_valid = 1'b0;
    logic [31:0] unlock_key = '0;
    logic [31:0] expected_key = KEY;
    logic        relock = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_level = '0;
    logic [3:0]  debug_level;
    logic [31:0] debug_output = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        unlocked;
    logic        locked_out;
    logic [2:0]  fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    debug_access_requester #(
        .SETTLE_CYCLES(SETTLE), .MAX_FAILS(3), .LOCKOUT_CYCLES(LOCKOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .unlock_valid(unlock_valid), .unlock_key(unlock_key), .expected_key(expected_key),
        .relock(relock),
        .req_valid(req_valid), .req_ready(req_ready), .req_level(req_level),
        .debug_level(debug_level), .debug_output(debug_output),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .unlocked(unlocked), .locked_out(locked_out), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    // Reference rules for a debug read.
    function automatic bit ref_drives(input logic [3:0] lvl);
        return lvl >= 4'hA;
    endfunction
    function automatic int ref_latency(input logic [3:0] lvl);
        return ref_drives(lvl) ? SETTLE + 1 : 1;
    endfunction
    function automatic logic [31:0] ref_data(input logic [3:0] lvl, input logic [31:0] d);
        return ref_drives(lvl) ? d : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_key(input logic [31:0] k);
        unlock_valid = 1'b1;
        unlock_key   = k;
        tick();
        unlock_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_unlocked"}, 32'(unlocked), 32'h0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_data"}, rsp_data, 32'h0);
        chk({tag, "_rsp_error"}, 32'(rsp_error), 32'h0);
        chk({tag, "_debug_level"}, 32'(debug_level), 32'h0);
        chk({tag, "_locked_out"}, 32'(locked_out), 32'h0);
    endtask

    // Issue one read and check the whole transaction against the rules.
    task automatic do_read(input string tag, input logic [3:0] lvl, input logic [31:0] d,
                           input int stall);
        int lat;
        bit got;
        debug_output = d;
        req_level    = lvl;
        req_valid    = 1'b1;
        chk({tag, "_req_ready"}, 32'(req_ready), 32'h1);
        lat = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            req_valid = 1'b0;
            lat++;
            if (rsp_valid) begin
                got = 1;
                break;
            end
            chk({tag, "_settle_level"}, 32'(debug_level), 32'(lvl));
        end
        chk({tag, "_rsp_seen"}, 32'(got), 32'h1);
        if (got) begin
            chk({tag, "_latency"}, 32'(lat), 32'(ref_latency(lvl)));
            chk({tag, "_rsp_data"}, rsp_data, ref_data(lvl, d));
            chk({tag, "_rsp_error"}, 32'(rsp_error), 32'(!ref_drives(lvl)));
            chk({tag, "_resp_level"}, 32'(debug_level), 32'h0);
            debug_output = $urandom;
            for (int s = 0; s < stall; s++) begin
                tick();
                chk({tag, "_stall_valid"}, 32'(rsp_valid), 32'h1);
                chk({tag, "_stall_data"}, rsp_data, ref_data(lvl, d));
                chk({tag, "_stall_error"}, 32'(rsp_error), 32'(!ref_drives(lvl)));
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk({tag, "_done_valid"}, 32'(rsp_valid), 32'h0);
            chk({tag, "_done_ready"}, 32'(req_ready), 32'h1);
        end
    endtask

    initial begin
        logic [31:0] wrong;
        int cnt;
        bit seen;

        // Reset state
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b1;
        tick();
        check_idle_outputs("post_reset");

        // relock while locked does nothing
        relock = 1'b1;
        tick();
        relock = 1'b0;
        chk("relock_locked_unlocked", 32'(unlocked), 32'h0);

        // Three wrong keys
        for (int i = 0; i < 3; i++) begin
            wrong = $urandom;
            if (wrong == KEY) wrong = ~KEY;
            pulse_key(wrong);
            if (i < 2) chk("wrong_key_locked_out", 32'(locked_out), 32'h0);
            chk("wrong_key_unlocked", 32'(unlocked), 32'h0);
        end
`ifdef DBG_REQ_LOCKOUT_EN
        chk("lockout_entered", 32'(locked_out), 32'h1);
        pulse_key(KEY);
        chk("lockout_key_ignored", 32'(unlocked), 32'h0);
        cnt = 2;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!locked_out) break;
            cnt++;
        end
        chk("lockout_duration", 32'(cnt), 32'(LOCKOUT));
        chk("lockout_exit_unlocked", 32'(unlocked), 32'h0);
`else
        chk("no_lockout", 32'(locked_out), 32'h0);
`endif

        // Correct key opens the session
        pulse_key(KEY);
        chk("unlock_unlocked", 32'(unlocked), 32'h1);
        chk("unlock_req_ready", 32'(req_ready), 32'h1);

        // Directed reads
        do_read("read_c", 4'hC, 32'h1234_5678, 0);
        do_read("read_9", 4'h9, $urandom, 5);
        do_read("read_a", 4'hA, $urandom, 1);
        do_read("read_f", 4'hF, $urandom, 2);
        do_read("read_0", 4'h0, $urandom, 0);

        // Random reads
        for (int i = 0; i < 40; i++) begin
            do_read("rand", 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3));
        end

        // relock during SETTLE discards the transaction
        debug_output = $urandom;
        req_level = 4'hB;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("settle_level", 32'(debug_level), 32'hB);
        relock = 1'b1;
        tick();
        relock = 1'b0;
        chk("relock_settle_unlocked", 32'(unlocked), 32'h0);
        chk("relock_settle_level", 32'(debug_level), 32'h0);
        chk("relock_settle_data", rsp_data, 32'h0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) seen = 1;
            tick();
        end
        chk("relock_settle_no_rsp", 32'(seen), 32'h0);

        // relock and req_valid together: relock wins
        pulse_key(KEY);
        chk("reunlock", 32'(unlocked), 32'h1);
        req_level = 4'hD;
        req_valid = 1'b1;
        relock    = 1'b1;
        chk("relock_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0;
        relock    = 1'b0;
        chk("relock_req_unlocked", 32'(unlocked), 32'h0);
        chk("relock_req_level", 32'(debug_level), 32'h0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid || debug_level != 4'h0) seen = 1;
            tick();
        end
        chk("relock_req_no_activity", 32'(seen), 32'h0);

        // relock during RESP
        pulse_key(KEY);
        req_level = 4'h2;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("resp_before_relock", 32'(rsp_valid), 32'h1);
        relock = 1'b1;
        tick();
        relock = 1'b0;
        chk("relock_resp_valid", 32'(rsp_valid), 32'h0);
        chk("relock_resp_error", 32'(rsp_error), 32'h0);
        chk("relock_resp_unlocked", 32'(unlocked), 32'h0);

        // Reset in the middle of RESP
        pulse_key(KEY);
        req_level = 4'hE;
        debug_output = $urandom;
        req_valid = 1'b1;
        for (int i = 0; i < SETTLE + 1; i++) begin
            tick();
            req_valid = 1'b0;
        end
        chk("pre_reset_resp", 32'(rsp_valid), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        tick();
        rst = 1'b1;
        tick();
        chk("reset_release_unlocked", 32'(unlocked), 32'h0);
        chk("reset_release_rsp_valid", 32'(rsp_valid), 32'h0);
        pulse_key(KEY);
        chk("after_reset_unlock", 32'(unlocked), 32'h1);
        chk("after_reset_no_rsp", 32'(rsp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
